// File: rtl/gpu_msg_pkg.sv
// Shared scheduler/core broadcast protocol definitions.
// Message kinds and strobe priority used by both ends of the bus.
package gpu_msg_pkg;

  localparam int MSG_W = 16;
  localparam int ID_W  = 4;

  typedef enum logic [2:0] {
    MSG_NONE,
    MSG_CORE_MASK,
    MSG_R0_MASK,
    MSG_R0,
    MSG_INS
  } msg_kind_e;

  // Strobes may collide; the highest-priority one wins.
  function automatic msg_kind_e msg_decode(
    input logic val_mask_ac,
    input logic val_mask_R0,
    input logic val_R0,
    input logic val_ins
  );
    msg_kind_e k;
    k = MSG_NONE;
    if (val_mask_ac)
      k = MSG_CORE_MASK;
    else if (val_mask_R0)
      k = MSG_R0_MASK;
    else if (val_R0)
      k = MSG_R0;
    else if (val_ins)
      k = MSG_INS;
    return k;
  endfunction

  function automatic logic msg_multi(
    input logic val_mask_ac,
    input logic val_mask_R0,
    input logic val_R0,
    input logic val_ins
  );
    logic [3:0] s;
    s = {val_mask_ac, val_mask_R0, val_R0, val_ins};
    return (s & (s - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/core_msg_rx_if.sv
// Scheduler-to-core broadcast bus with per-core
// rtr/ready return lines.
interface core_msg_rx_if #(
  parameter int MSG_W = gpu_msg_pkg::MSG_W
);

  logic             val_ins;
  logic             val_mask_ac;
  logic             val_mask_R0;
  logic             val_R0;
  logic [MSG_W-1:0] instruction;
  logic             rtr;
  logic             ready;

  modport master (
    output val_ins,
    output val_mask_ac,
    output val_mask_R0,
    output val_R0,
    output instruction,
    input  rtr,
    input  ready
  );

  modport slave (
    input  val_ins,
    input  val_mask_ac,
    input  val_mask_R0,
    input  val_R0,
    input  instruction,
    output rtr,
    output ready
  );

endinterface

// File: rtl/msg_fifo.sv
// Circular instruction FIFO; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module msg_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          drop
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_msg_rx.sv
// Per-core receiver for the scheduler broadcast bus:
// strobe decode, mask filtering, R0 latch, instruction FIFO.
module core_msg_rx #(
  parameter  int DEPTH = 4,
  parameter  int MSG_W = gpu_msg_pkg::MSG_W,
  parameter  int ID_W  = gpu_msg_pkg::ID_W,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ID_W-1:0]  core_id,
  core_msg_rx_if.slave     bus,
  output logic [MSG_W-1:0] ins_out,
  output logic             ins_valid,
  input  logic             ins_pop,
  input  logic             exec_busy,
  output logic [MSG_W-1:0] r0_val,
  output logic             r0_upd,
  output logic             active,
  output logic             proto_err
);

  import gpu_msg_pkg::*;

  msg_kind_e kind;
  logic      multi;
  logic      sel_bit;
  logic      r0_sel;
  logic      push;
  logic      drop;
  logic [CW-1:0] count;

  assign kind = msg_decode(bus.val_mask_ac,
                           bus.val_mask_R0,
                           bus.val_R0,
                           bus.val_ins);

  assign multi = msg_multi(bus.val_mask_ac,
                           bus.val_mask_R0,
                           bus.val_R0,
                           bus.val_ins);

  assign sel_bit = bus.instruction[core_id];
  assign push    = (kind == MSG_INS) && active;

  always_ff @(posedge clk) begin
    if (reset) begin
      active    <= 1'b0;
      r0_sel    <= 1'b0;
      r0_val    <= '0;
      r0_upd    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      r0_upd <= 1'b0;
      if (kind == MSG_CORE_MASK)
        active <= sel_bit;
      if (kind == MSG_R0_MASK)
        r0_sel <= sel_bit;
      if (kind == MSG_R0 && r0_sel) begin
        r0_val <= bus.instruction;
        r0_upd <= 1'b1;
      end
      if (multi || drop)
        proto_err <= 1'b1;
    end
  end

  msg_fifo #(
    .DEPTH (DEPTH),
    .W     (MSG_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (ins_pop),
    .din   (bus.instruction),
    .dout  (ins_out),
    .count (count),
    .drop  (drop)
  );

  assign ins_valid = (count != '0);
  assign bus.rtr   = (count != CW'(DEPTH)) && !reset;
  assign bus.ready = (count == '0) && !exec_busy
                   && !r0_upd;

endmodule

// File: tb/tb_core_msg_rx.sv
// Directed self-checking bench for core_msg_rx
// with core_id 5 and a 4-deep FIFO.
module tb_core_msg_rx;

  logic        clk;
  logic        reset;
  logic [3:0]  core_id;
  logic [15:0] ins_out;
  logic        ins_valid;
  logic        ins_pop;
  logic        exec_busy;
  logic [15:0] r0_val;
  logic        r0_upd;
  logic        active;
  logic        proto_err;

  int passed;
  int total;

  core_msg_rx_if #(.MSG_W(16)) bus ();

  core_msg_rx #(
    .DEPTH (4),
    .MSG_W (16),
    .ID_W  (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core_id   (core_id),
    .bus       (bus),
    .ins_out   (ins_out),
    .ins_valid (ins_valid),
    .ins_pop   (ins_pop),
    .exec_busy (exec_busy),
    .r0_val    (r0_val),
    .r0_upd    (r0_upd),
    .active    (active),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.val_ins     = 1'b0;
    bus.val_mask_ac = 1'b0;
    bus.val_mask_R0 = 1'b0;
    bus.val_R0      = 1'b0;
    bus.instruction = 16'h0000;
    ins_pop         = 1'b0;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h",
                tag, obs, exp);
  endtask

  task automatic send_ac(input logic [15:0] m);
    bus.val_mask_ac = 1'b1;
    bus.instruction = m;
    tick();
    idle();
  endtask

  task automatic send_ins(input logic [15:0] v,
                          input logic pop);
    bus.val_ins     = 1'b1;
    bus.instruction = v;
    ins_pop         = pop;
    tick();
    idle();
  endtask

  task automatic do_pop();
    ins_pop = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    core_id   = 4'd5;
    exec_busy = 1'b0;
    idle();
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", 16'(ins_valid), 16'h0);
    chk("rst_active", 16'(active), 16'h0);
    chk("rst_r0", r0_val, 16'h0000);
    chk("rst_err", 16'(proto_err), 16'h0);
    chk("rst_rtr_in_reset", 16'(bus.rtr), 16'h0);
    reset = 1'b0;
    #1;
    chk("rtr_after_rst", 16'(bus.rtr), 16'h1);
    chk("ready_after_rst", 16'(bus.ready), 16'h1);

    // Active core receives one instruction
    send_ac(16'h0020);
    chk("act_on", 16'(active), 16'h1);
    send_ins(16'hA1B2, 1'b0);
    chk("t1_valid", 16'(ins_valid), 16'h1);
    chk("t1_out", ins_out, 16'hA1B2);
    chk("t1_rtr", 16'(bus.rtr), 16'h1);
    chk("t1_ready", 16'(bus.ready), 16'h0);
    do_pop();
    chk("t1_drained", 16'(ins_valid), 16'h0);
    do_pop();
    chk("pop_empty", 16'(ins_valid), 16'h0);

    // Inactive core ignores instructions
    send_ac(16'h0010);
    chk("act_off", 16'(active), 16'h0);
    send_ins(16'h1234, 1'b0);
    chk("t2_valid", 16'(ins_valid), 16'h0);
    chk("t2_err", 16'(proto_err), 16'h0);
    chk("t2_ready", 16'(bus.ready), 16'h1);

    // R0 select and latch
    bus.val_mask_R0 = 1'b1;
    bus.instruction = 16'h0020;
    tick();
    idle();
    bus.val_R0      = 1'b1;
    bus.instruction = 16'hBEEF;
    tick();
    idle();
    chk("r0_val", r0_val, 16'hBEEF);
    chk("r0_upd_hi", 16'(r0_upd), 16'h1);
    chk("r0_ready_lo", 16'(bus.ready), 16'h0);
    tick();
    chk("r0_upd_lo", 16'(r0_upd), 16'h0);
    chk("r0_ready_hi", 16'(bus.ready), 16'h1);
    bus.val_mask_R0 = 1'b1;
    bus.instruction = 16'h0000;
    tick();
    idle();
    bus.val_R0      = 1'b1;
    bus.instruction = 16'h1111;
    tick();
    idle();
    chk("r0_unsel", r0_val, 16'hBEEF);
    chk("r0_unsel_upd", 16'(r0_upd), 16'h0);

    // Colliding strobes: core mask wins
    bus.val_ins     = 1'b1;
    bus.val_mask_ac = 1'b1;
    bus.instruction = 16'h0020;
    tick();
    idle();
    chk("multi_active", 16'(active), 16'h1);
    chk("multi_fifo", 16'(ins_valid), 16'h0);
    chk("multi_err", 16'(proto_err), 16'h1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("err_cleared", 16'(proto_err), 16'h0);

    // Fill, pass-through when full, then overflow
    send_ac(16'h0020);
    for (int i = 1; i <= 4; i++) begin
      chk("fill_rtr", 16'(bus.rtr), 16'h1);
      send_ins(16'(i), 1'b0);
    end
    chk("full_rtr", 16'(bus.rtr), 16'h0);
    chk("full_head", ins_out, 16'h0001);
    send_ins(16'h0005, 1'b1);
    chk("pt_head", ins_out, 16'h0002);
    chk("pt_rtr", 16'(bus.rtr), 16'h0);
    chk("pt_err", 16'(proto_err), 16'h0);
    send_ins(16'h0006, 1'b0);
    chk("ovf_err", 16'(proto_err), 16'h1);
    chk("ovf_head", ins_out, 16'h0002);
    for (int i = 2; i <= 5; i++) begin
      chk("drain_out", ins_out, 16'(i));
      chk("drain_valid", 16'(ins_valid), 16'h1);
      do_pop();
      chk("drain_rtr", 16'(bus.rtr), 16'h1);
    end
    chk("drain_empty", 16'(ins_valid), 16'h0);

    // Reset with three entries queued
    send_ins(16'h00A1, 1'b0);
    send_ins(16'h00A2, 1'b0);
    send_ins(16'h00A3, 1'b0);
    chk("pre_rst_valid", 16'(ins_valid), 16'h1);
    reset = 1'b1;
    bus.val_ins     = 1'b1;
    bus.instruction = 16'h00A4;
    tick();
    idle();
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 16'(ins_valid), 16'h0);
    chk("mid_rst_active", 16'(active), 16'h0);
    chk("mid_rst_rtr", 16'(bus.rtr), 16'h1);
    chk("mid_rst_r0", r0_val, 16'h0000);
    chk("mid_rst_err", 16'(proto_err), 16'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
